// File: rtl/timing_phase_gen.sv
// rtl/timing_phase_gen.sv - W/X/Y/Z phase-clock drive generator with bit-time counter.
// Optional sequencing checker enabled by defining TIMING_CHECK_EN.
module timing_phase_gen #(
  parameter int DIV_CYCLES     = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int BITS_PER_CYCLE = 14,
  parameter int BIT_W          = 4
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             RUN,
  input  logic             STEP,
  output logic             WDA,
  output logic             XDA,
  output logic             YDA,
  output logic             ZDA,
  output logic [1:0]       PHASE,
  output logic [BIT_W-1:0] BIT_TIME,
  output logic             CYCLE_END,
  output logic             HALTED,
  output logic             TIMING_ERR
);

  localparam int SUB_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DIV_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_GAP  = SUB_W'(GAP_CYCLES);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_CYCLE - 1);

  localparam logic [1:0] MODE_HALT = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  logic [1:0]       mode, mode_nx;
  logic [SUB_W-1:0] sub, sub_nx;
  logic [1:0]       phase_nx;
  logic [BIT_W-1:0] bit_nx;
  logic             wrap;
  logic [3:0]       da_nx;

  always_comb begin
    mode_nx  = mode;
    sub_nx   = sub;
    phase_nx = PHASE;
    bit_nx   = BIT_TIME;
    wrap     = 1'b0;
    case (mode)
      MODE_HALT: begin
        sub_nx   = '0;
        phase_nx = 2'd0;
        if (RUN)       mode_nx = MODE_RUN;
        else if (STEP) mode_nx = MODE_STEP;
      end
      default: begin
        if (sub == SUB_LAST) begin
          sub_nx   = '0;
          phase_nx = PHASE + 2'd1;
        end else begin
          sub_nx = sub + 1'b1;
        end
        // RUN only matters here, so a bit time is never cut short
        if (PHASE == 2'd3 && sub == SUB_LAST) begin
          wrap   = (BIT_TIME == BIT_LAST);
          bit_nx = wrap ? '0 : BIT_TIME + 1'b1;
          if (mode == MODE_STEP || !RUN) mode_nx = MODE_HALT;
        end
      end
    endcase
    // Drives are decoded from next state so they stay registered yet aligned
    da_nx = 4'b0000;
    if (mode_nx != MODE_HALT && sub_nx >= SUB_GAP) da_nx[phase_nx] = 1'b1;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      mode                   <= MODE_HALT;
      sub                    <= '0;
      PHASE                  <= 2'd0;
      BIT_TIME               <= '0;
      {ZDA, YDA, XDA, WDA}   <= 4'b0000;
      CYCLE_END              <= 1'b0;
      HALTED                 <= 1'b1;
    end else begin
      mode                   <= mode_nx;
      sub                    <= sub_nx;
      PHASE                  <= phase_nx;
      BIT_TIME               <= bit_nx;
      {ZDA, YDA, XDA, WDA}   <= da_nx;
      CYCLE_END              <= wrap;
      HALTED                 <= (mode_nx == MODE_HALT);
    end
  end

`ifdef TIMING_CHECK_EN
  logic [3:0] da_q;
  logic [3:0] last_da;

  assign da_q = {ZDA, YDA, XDA, WDA};

  // last_da starts at Z so that W is the only legal first drive
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      TIMING_ERR <= 1'b0;
      last_da    <= 4'b1000;
    end else begin
      if (($countones(da_q) > 1) || (HALTED && da_q != 4'b0000) ||
          (da_q != 4'b0000 && da_q != last_da && da_q != {last_da[2:0], last_da[3]}))
        TIMING_ERR <= 1'b1;
      if (da_q != 4'b0000) last_da <= da_q;
    end
  end
`else
  assign TIMING_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_timing_phase_gen.sv
// tb/tb_timing_phase_gen.sv - scoreboard bench for timing_phase_gen.
module tb_timing_phase_gen;

  localparam int BW  = 4;
  localparam int DIV = 4;
  localparam int GAP = 1;

  typedef logic [BW+7:0] vec_t;

  logic          SIM_CLK = 1'b0;
  logic          SIM_RST;
  logic          RUN;
  logic          STEP;
  logic          WDA, XDA, YDA, ZDA;
  logic [1:0]    PHASE;
  logic [BW-1:0] BIT_TIME;
  logic          CYCLE_END, HALTED, TIMING_ERR;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t obs, exp_v;
  logic exp_err;

  assign obs = {HALTED, CYCLE_END, BIT_TIME, PHASE, ZDA, YDA, XDA, WDA};

  timing_phase_gen #(
    .DIV_CYCLES(DIV), .GAP_CYCLES(GAP), .BITS_PER_CYCLE(14), .BIT_W(BW)
  ) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN), .STEP(STEP),
    .WDA(WDA), .XDA(XDA), .YDA(YDA), .ZDA(ZDA),
    .PHASE(PHASE), .BIT_TIME(BIT_TIME), .CYCLE_END(CYCLE_END),
    .HALTED(HALTED), .TIMING_ERR(TIMING_ERR)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  function automatic vec_t exp_vec(input logic h, input logic ce, input logic [BW-1:0] bt,
                                   input logic [1:0] ph, input logic [3:0] da);
    return {h, ce, bt, ph, da};
  endfunction

  // One bit time from its first cycle: phase = j/DIV, drive high once sub >= GAP
  task automatic push_bit(input int b, input logic ce);
    logic [1:0] ph;
    logic [3:0] da;
    for (int j = 0; j < 4 * DIV; j++) begin
      ph = 2'(j / DIV);
      da = ((j % DIV) >= GAP) ? 4'(1 << (j / DIV)) : 4'b0000;
      sb.push_back(exp_vec(1'b0, ce && (j == 0), BW'(b), ph, da));
    end
  endtask

  task automatic push_halt(input int n, input int b);
    for (int j = 0; j < n; j++) sb.push_back(exp_vec(1'b1, 1'b0, BW'(b), 2'd0, 4'b0000));
  endtask

  task automatic test_reset;
    SIM_RST = 1'b0; RUN = 1'b0; STEP = 1'b0;
    repeat (3) @(negedge SIM_CLK);
    n_cmp++;
    if (obs !== exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000) || TIMING_ERR !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold: got %h err %b want %h err 0", obs, TIMING_ERR,
                        exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000));
    end
    SIM_RST = 1'b1;
    repeat (2) @(negedge SIM_CLK);
    n_cmp++;
    if (obs !== exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000)) begin
      n_bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000));
    end
  endtask

  task automatic test_free_run;
    int i;
    RUN = 1'b1;
    for (int b = 0; b < 14; b++) push_bit(b, 1'b0);
    push_bit(0, 1'b1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge SIM_CLK);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL free_run cyc %0d: got %h want %h", i, obs, exp_v);
      end
      i++;
    end
  endtask

  task automatic test_run_stop;
    int i;
    for (int b = 1; b < 6; b++) push_bit(b, 1'b0);
    push_halt(4, 6);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge SIM_CLK);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL run_stop cyc %0d: got %h want %h", i, obs, exp_v);
      end
      if (i == 4 * 4 * DIV + DIV + 1) RUN = 1'b0;
      i++;
    end
  endtask

  task automatic test_step;
    int i;
    STEP = 1'b1;
    push_bit(6, 1'b0);
    push_halt(6, 7);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge SIM_CLK);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL step cyc %0d: got %h want %h", i, obs, exp_v);
      end
      if (i == 0) STEP = 1'b0;
      if (i == 6) STEP = 1'b1;
      if (i == 7) STEP = 1'b0;
      i++;
    end
    n_cmp++;
    if (TIMING_ERR !== 1'b0) begin
      n_bad++; $display("FAIL step_no_err: got %b want 0", TIMING_ERR);
    end
  endtask

  task automatic test_reset_mid;
    RUN = 1'b1;
    push_bit(7, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge SIM_CLK);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL reset_mid_run cyc %0d: got %h want %h", i, obs, exp_v);
      end
    end
    sb.delete();
    #2 SIM_RST = 1'b0;
    #1;
    n_cmp++;
    if (obs !== exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000)) begin
      n_bad++; $display("FAIL reset_mid_async: got %h want %h", obs, exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000));
    end
    RUN = 1'b0;
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    repeat (2) @(negedge SIM_CLK);
    n_cmp++;
    if (obs !== exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000)) begin
      n_bad++; $display("FAIL reset_mid_after: got %h want %h", obs, exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000));
    end
  endtask

  task automatic test_timing_check;
`ifdef TIMING_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    force dut.WDA = 1'b1;
    force dut.XDA = 1'b1;
    repeat (2) @(negedge SIM_CLK);
    release dut.WDA;
    release dut.XDA;
    repeat (3) @(negedge SIM_CLK);
    n_cmp++;
    if (TIMING_ERR !== exp_err) begin
      n_bad++; $display("FAIL timing_err_sticky: got %b want %b", TIMING_ERR, exp_err);
    end
    n_cmp++;
    if (obs !== exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000)) begin
      n_bad++; $display("FAIL timing_da_idle: got %h want %h", obs, exp_vec(1'b1, 1'b0, '0, 2'd0, 4'b0000));
    end
    SIM_RST = 1'b0;
    #1;
    n_cmp++;
    if (TIMING_ERR !== 1'b0) begin
      n_bad++; $display("FAIL timing_err_clear: got %b want 0", TIMING_ERR);
    end
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    @(negedge SIM_CLK);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_run_stop();
    test_step();
    test_reset_mid();
    test_timing_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/timing_phase_gen.md
Name: timing_phase_gen

Overview:
- Generates the four LVDA phase-clock drive signals WDA, XDA, YDA and ZDA from the simulation clock.
- These four signals feed the phase-clock fan-out stage, which buffers them into W1..W8, X1..X8, Y1..Y8 and Z1..Z8.
- Sequences phases W→X→Y→Z, one-hot and non-overlapping, with a dead band at the start of each phase.
- Counts bit times within a computer cycle; supports free-run, clean halt and single-bit-time step.

Parameters:
- DIV_CYCLES, 4: SIM_CLK cycles per phase. Legal values ≥2.
- GAP_CYCLES, 1: dead cycles at the start of each phase with all DA outputs low. Legal range 0..DIV_CYCLES-1.
- BITS_PER_CYCLE, 14: bit times per computer cycle. Must be ≤2^BIT_W.
- BIT_W, 4: width of BIT_TIME.

Ports:
- SIM_CLK  in  1  system clock.
- SIM_RST  in  1  asynchronous, active-low reset.
- RUN  in  1  level; high = free-run phase generation.
- STEP  in  1  single-cycle pulse; runs exactly one bit time while halted.
- WDA  out  1  W phase drive.
- XDA  out  1  X phase drive.
- YDA  out  1  Y phase drive.
- ZDA  out  1  Z phase drive.
- PHASE  out  2  current phase: 0=W, 1=X, 2=Y, 3=Z.
- BIT_TIME  out  BIT_W  current bit time, 0..BITS_PER_CYCLE-1.
- CYCLE_END  out  1  one-clock pulse on the last bit time's wrap.
- HALTED  out  1  generator idle.
- TIMING_ERR  out  1  sticky sequencing fault (see Optional Feature).

Behaviour:
- Reset (SIM_RST low, asynchronous): the following values apply immediately and hold while reset is low.
  - Mode=HALT, sub=0, PHASE=0, BIT_TIME=0.
  - All DA outputs low, CYCLE_END=0, HALTED=1, TIMING_ERR=0.
- Reset asserted mid-operation aborts the current bit time; no partial-phase completion.
- State: mode {HALT, RUN, STEP}, sub counter 0..DIV_CYCLES-1, PHASE, BIT_TIME.
- All outputs are flop outputs, with no combinational path from inputs to outputs.
- HALT:
  - sub=0, PHASE=0, all DA low, HALTED=1.
  - RUN sampled high → mode RUN on that edge.
  - Otherwise, STEP sampled high → mode STEP on that edge.
  - RUN and STEP both high → RUN wins; STEP is discarded.
- RUN/STEP, per clock:
  - sub increments.
  - At sub==DIV_CYCLES-1: sub←0 and PHASE←PHASE+1 (wraps 3→0).
- DA decode: the DA for PHASE is high in cycles where GAP_CYCLES ≤ sub ≤ DIV_CYCLES-1. All other DAs are low.
  - At most one DA is ever high.
  - Per phase: GAP_CYCLES dead cycles, then DIV_CYCLES-GAP_CYCLES high cycles.
- Bit-time boundary (PHASE==3 and sub==DIV_CYCLES-1):
  - BIT_TIME increments. At BITS_PER_CYCLE-1 it wraps to 0, and CYCLE_END is high for the following cycle only.
  - If mode==STEP, or mode==RUN with RUN low: next mode=HALT (sub=0, PHASE=0), HALTED=1 the following cycle.
  - Otherwise the generator continues at PHASE=0.
- RUN is examined only at the bit-time boundary; deassertion never truncates a bit time.
- RUN reasserted before the boundary → no stop.
- STEP outside HALT is ignored.
- BIT_TIME is retained across HALT; only reset clears it.
- HALTED=0 from the start edge until the returning boundary edge.
- Start latency: RUN high at edge k → HALTED low and sub=0 after edge k. First WDA high cycle follows edge k+GAP_CYCLES.
- Bit-time period = 4×DIV_CYCLES clocks (16 at defaults).

Optional Feature:
- Macro TIMING_CHECK_EN.
- Defined: checker monitors the registered DA outputs every clock. TIMING_ERR sets and stays set until reset when any of the following occurs:
  - more than one DA is high;
  - any DA is high while HALTED=1;
  - the phase order deviates from W→X→Y→Z.
- Not defined: no checker logic; TIMING_ERR is tied 0. The port remains present so instantiations do not change.

Test Plan:
- Reset with RUN=0 → all DA low, HALTED=1, BIT_TIME=0. Asserting SIM_RST low mid-phase clears everything asynchronously.
- Defaults, RUN=1 held → each phase: 1 dead cycle then 3 high cycles, sequence W,X,Y,Z, 16-clock bit time. DAs one-hot; never two high.
- RUN=1 for 14×16 clocks → BIT_TIME 0..13 then 0. CYCLE_END pulses exactly once, 1 clock wide, at the 13→0 wrap.
- RUN dropped during X phase of bit time 5 → Y and Z phases complete. BIT_TIME=6, HALTED=1 one clock after the Z boundary; no DA afterwards.
- HALT, STEP pulse at BIT_TIME=6 → exactly one W,X,Y,Z sequence, BIT_TIME=7, return to HALT. A second STEP during that bit time is ignored.
- With TIMING_CHECK_EN, force two DA high via a bench force → TIMING_ERR=1 sticky until SIM_RST. Without the macro, TIMING_ERR stays 0.
